svp_rom_prefetch: RTL and testbench

Read-prefetch line buffer between the SVP core's ROM fetch port and port B of the SVP ROM dual-port arbiter. It serves sequential SVP instruction and ROM-data fetches from a small buffer of one aligned line. This cuts arbiter traffic and leaves more memory slots for 68k cartridge reads. Misses fetch the critical word first, then fill the rest of the line in the background, wrapping within the line.

---
 rtl/svp_rom_prefetch.sv | 217 +++++++++++++++++++++
 tb/tb_svp_rom_prefetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/svp_rom_prefetch.sv
// One-line read-prefetch buffer between the SVP ROM fetch port and arbiter port B.
// Optional hit/miss statistics are enabled with `define SVP_ROM_PF_STATS_EN.
module svp_rom_prefetch #(
  parameter int ADDR_W    = 20,
  parameter int LINE_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] svp_addr,
  input  logic              svp_req,
  output logic              svp_ack,
  output logic [15:0]       svp_do,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_oe,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_do,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);
  localparam int WORDS = 1 << LINE_LOG2;
  localparam int TAG_W = ADDR_W - LINE_LOG2;
  localparam logic [LINE_LOG2:0] FULL_LINE = (LINE_LOG2 + 1)'(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t               r_state, w_state_nxt;
  logic [TAG_W-1:0]     r_line_base, w_line_base_nxt;
  logic                 r_line_vld, w_line_vld_nxt;
  logic [WORDS-1:0]     r_valid, w_valid_nxt;
  logic [15:0]          r_data [WORDS];
  logic [15:0]          w_data_nxt [WORDS];
  logic [LINE_LOG2-1:0] r_fill_ptr, w_fill_ptr_nxt;
  logic [LINE_LOG2:0]   r_fill_left, w_fill_left_nxt;
  logic                 r_svp_ack, w_svp_ack_nxt;
  logic [15:0]          r_svp_do, w_svp_do_nxt;
  logic [ADDR_W-1:0]    r_mem_addr, w_mem_addr_nxt;
  logic                 r_mem_oe, w_mem_oe_nxt;
  logic                 r_mem_req, w_mem_req_nxt;

  logic [TAG_W-1:0]     w_tag;
  logic [LINE_LOG2-1:0] w_idx;
  logic                 w_pend, w_in_line, w_miss, w_mem_done;
  logic                 w_hit, w_fwd, w_miss_start;

  assign w_tag      = svp_addr[ADDR_W-1:LINE_LOG2];
  assign w_idx      = svp_addr[LINE_LOG2-1:0];
  assign w_pend     = (svp_req != r_svp_ack);
  assign w_in_line  = r_line_vld && (w_tag == r_line_base);
  assign w_miss     = w_pend && !w_in_line;
  assign w_mem_done = (mem_ack == r_mem_req);

  // A flush suppresses hits on its edge so a pending request re-evaluates as a miss.
  always_comb begin
    w_state_nxt     = r_state;
    w_line_base_nxt = r_line_base;
    w_line_vld_nxt  = r_line_vld;
    w_valid_nxt     = r_valid;
    w_data_nxt      = r_data;
    w_fill_ptr_nxt  = r_fill_ptr;
    w_fill_left_nxt = r_fill_left;
    w_svp_ack_nxt   = r_svp_ack;
    w_svp_do_nxt    = r_svp_do;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_oe_nxt    = r_mem_oe;
    w_mem_req_nxt   = r_mem_req;
    w_hit           = 1'b0;
    w_fwd           = 1'b0;
    w_miss_start    = 1'b0;

    if (flush) begin
      w_valid_nxt    = '0;
      w_line_vld_nxt = 1'b0;
      case (r_state)
        S_WAIT, S_DRAIN: begin
          if (w_mem_done) begin
            w_mem_oe_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_state_nxt  = S_DRAIN;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else begin
      w_hit = w_pend && w_in_line && r_valid[w_idx];
      case (r_state)
        S_IDLE: w_miss_start = w_miss;
        S_ISSUE: begin
          if (w_miss) begin
            w_miss_start = 1'b1;
          end else begin
            w_mem_addr_nxt = {r_line_base, r_fill_ptr};
            w_mem_oe_nxt   = 1'b1;
            w_mem_req_nxt  = ~r_mem_req;
            w_state_nxt    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_mem_done) begin
            w_data_nxt[r_fill_ptr]  = mem_do;
            w_valid_nxt[r_fill_ptr] = 1'b1;
            w_mem_oe_nxt            = 1'b0;
            w_fill_ptr_nxt          = r_fill_ptr + 1'b1;
            w_fill_left_nxt         = r_fill_left - 1'b1;
            w_fwd = w_pend && w_in_line && (w_idx == r_fill_ptr);
            if (w_miss)
              w_miss_start = 1'b1;
            else if (r_fill_left == 1)
              w_state_nxt = S_IDLE;
            else
              w_state_nxt = S_ISSUE;
          end else if (w_miss) begin
            w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_mem_done) begin
            w_mem_oe_nxt = 1'b0;
            if (w_miss)
              w_miss_start = 1'b1;
            else
              w_state_nxt = S_IDLE;
          end
        end
      endcase

      if (w_hit) begin
        w_svp_ack_nxt = ~r_svp_ack;
        w_svp_do_nxt  = r_data[w_idx];
      end else if (w_fwd) begin
        w_svp_ack_nxt = ~r_svp_ack;
        w_svp_do_nxt  = mem_do;
      end

      if (w_miss_start) begin
        w_line_base_nxt = w_tag;
        w_line_vld_nxt  = 1'b1;
        w_valid_nxt     = '0;
        w_fill_ptr_nxt  = w_idx;
        w_fill_left_nxt = FULL_LINE;
        w_state_nxt     = S_ISSUE;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_line_base <= '0;
      r_line_vld  <= 1'b0;
      r_valid     <= '0;
      r_fill_ptr  <= '0;
      r_fill_left <= '0;
      r_svp_ack   <= svp_req;
      r_svp_do    <= '0;
      r_mem_addr  <= '0;
      r_mem_oe    <= 1'b0;
      r_mem_req   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_line_base <= w_line_base_nxt;
      r_line_vld  <= w_line_vld_nxt;
      r_valid     <= w_valid_nxt;
      r_fill_ptr  <= w_fill_ptr_nxt;
      r_fill_left <= w_fill_left_nxt;
      r_svp_ack   <= w_svp_ack_nxt;
      r_svp_do    <= w_svp_do_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_oe    <= w_mem_oe_nxt;
      r_mem_req   <= w_mem_req_nxt;
    end
  end

  // Line data needs no reset: the valid bits guard every read.
  always_ff @(negedge clk) begin
    r_data <= w_data_nxt;
  end

  assign svp_ack  = r_svp_ack;
  assign svp_do   = r_svp_do;
  assign mem_addr = r_mem_addr;
  assign mem_oe   = r_mem_oe;
  assign mem_req  = r_mem_req;

`ifdef SVP_ROM_PF_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;
  logic        r_miss_owner;

  // The request that started a miss is served by forwarding but is not counted as a hit.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_miss_owner <= 1'b0;
    end else begin
      if (w_miss_start) begin
        r_miss_owner <= 1'b1;
        if (r_miss_cnt != 16'hFFFF)
          r_miss_cnt <= r_miss_cnt + 1'b1;
      end else if (w_hit || w_fwd) begin
        r_miss_owner <= 1'b0;
      end
      if ((w_hit || (w_fwd && !r_miss_owner)) && (r_hit_cnt != 16'hFFFF))
        r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_svp_rom_prefetch.sv
// Directed self-checking bench for svp_rom_prefetch with a 3-cycle toggle-handshake arbiter model.
`timescale 1ns/1ps
module tb_svp_rom_prefetch;
  localparam int ADDR_W  = 20;
  localparam int ARB_LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] svp_addr = '0;
  logic              svp_req = 1'b0;
  logic              svp_ack;
  logic [15:0]       svp_do;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_oe;
  logic              mem_req;
  logic              mem_ack = 1'b0;
  logic [15:0]       mem_do = '0;
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;

  int total = 0;
  int bad = 0;
  logic [ADDR_W-1:0] fetchLog [64];
  int fetchCount = 0;
  int arbCnt = 0;

  svp_rom_prefetch #(.ADDR_W(ADDR_W), .LINE_LOG2(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .svp_addr(svp_addr), .svp_req(svp_req), .svp_ack(svp_ack), .svp_do(svp_do),
    .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_do(mem_do), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] romWord(input logic [ADDR_W-1:0] a);
    return (a[15:0] * 16'd7) ^ {a[19:16], 12'hC35};
  endfunction

  // Arbiter model: logs each new fetch and answers ARB_LAT cycles after the mem_req toggle.
  always @(posedge clk) begin
    if (rst) begin
      mem_ack    = mem_req;
      arbCnt     = 0;
      fetchCount = 0;
    end else if (mem_req != mem_ack) begin
      if (arbCnt == 0) begin
        if (fetchCount < 64) fetchLog[fetchCount] = mem_addr;
        fetchCount++;
      end
      arbCnt++;
      if (arbCnt == ARB_LAT) begin
        mem_do  = romWord(mem_addr);
        mem_ack = mem_req;
        arbCnt  = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input int expLat, input string tag);
    int lat;
    svp_addr = addr;
    svp_req  = ~svp_req;
    lat = 0;
    while (svp_ack !== svp_req && lat < 60) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_data"}, {16'h0, svp_do}, {16'h0, romWord(addr)});
  endtask

  task automatic waitFetches(input int target, input string tag);
    int cyc;
    cyc = 0;
    while (!(fetchCount == target && mem_oe == 1'b0 && mem_req == mem_ack) && cyc < 200) begin
      tick();
      cyc++;
    end
    checkOutput({tag, "_fetches"}, fetchCount, target);
    checkOutput({tag, "_oe"}, {31'h0, mem_oe}, 32'h0);
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ack"}, {31'h0, svp_ack}, {31'h0, svp_req});
    checkOutput({tag, "_do"}, {16'h0, svp_do}, 32'h0);
    checkOutput({tag, "_maddr"}, {12'h0, mem_addr}, 32'h0);
    checkOutput({tag, "_oe"}, {31'h0, mem_oe}, 32'h0);
    checkOutput({tag, "_mreq"}, {31'h0, mem_req}, 32'h0);
    checkOutput({tag, "_hits"}, {16'h0, hit_cnt}, 32'h0);
    checkOutput({tag, "_misses"}, {16'h0, miss_cnt}, 32'h0);
  endtask

  initial begin
    logic [ADDR_W-1:0] fillOrder [4];
    fillOrder[0] = 20'h00102;
    fillOrder[1] = 20'h00103;
    fillOrder[2] = 20'h00100;
    fillOrder[3] = 20'h00101;

    repeat (3) tick();
    rst = 1'b0;
    checkResetState("reset");

    // Critical word first, wrap within the line.
    applyStimulus(20'h00102, 5, "miss102");
    waitFetches(4, "fill102");
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("order%0d", i), {12'h0, fetchLog[i]}, {12'h0, fillOrder[i]});

    // Back-to-back hits with no downstream traffic.
    for (int i = 0; i < 4; i++)
      applyStimulus(20'h00100 + ADDR_W'(i), 1, $sformatf("hit10%0d", i));
    checkOutput("hitNoFetch", fetchCount, 4);

    // Pending-word hit: forwarded on the edge the word returns.
    pulseFlush();
    applyStimulus(20'h00102, 5, "reMiss102");
    applyStimulus(20'h00103, 4, "pendWord103");
    checkOutput("fwdFetchCnt", fetchCount, 6);
    checkOutput("fwdFetchAddr", {12'h0, fetchLog[5]}, 32'h00103);

    // Flush while the 0x00100 fetch is outstanding, then 0x00100 must refetch.
    tick();
    checkOutput("oeBeforeFlush", {31'h0, mem_oe}, 32'h1);
    pulseFlush();
    waitFetches(7, "drainFlush");
    applyStimulus(20'h00100, 5, "flushRefetch");
    checkOutput("refetchCnt", fetchCount, 8);
    checkOutput("refetchAddr", {12'h0, fetchLog[7]}, 32'h00100);

    // Miss to another line while 0x00103 is outstanding.
    waitFetches(11, "fill100");
    pulseFlush();
    applyStimulus(20'h00102, 5, "miss102b");
    tick();
    applyStimulus(20'h08000, 7, "drainMiss");
    checkOutput("drainDiscard", {12'h0, fetchLog[12]}, 32'h00103);
    checkOutput("drainNext", {12'h0, fetchLog[13]}, 32'h08000);
    waitFetches(17, "fill8000");
    checkOutput("wrapLast", {12'h0, fetchLog[16]}, 32'h08003);
    applyStimulus(20'h08003, 1, "hit8003");

    // Statistics: one miss then seven hits, rst clears.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checkResetState("reset2");
    applyStimulus(20'h00102, 5, "statMiss");
    waitFetches(4, "statFill");
    for (int i = 0; i < 7; i++)
      applyStimulus(20'h00100 + ADDR_W'(i % 4), 1, $sformatf("statHit%0d", i));
`ifdef SVP_ROM_PF_STATS_EN
    checkOutput("hitCnt", {16'h0, hit_cnt}, 32'd7);
    checkOutput("missCnt", {16'h0, miss_cnt}, 32'd1);
`else
    checkOutput("hitCnt", {16'h0, hit_cnt}, 32'd0);
    checkOutput("missCnt", {16'h0, miss_cnt}, 32'd0);
`endif
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checkResetState("reset3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
